// File: rtl/dram_timing_pkg.sv
// Shared types and default timing for the DRAM strobe generator.
package dram_timing_pkg;

  localparam int unsigned ROW_W  = 8;
  localparam int unsigned COL_W  = 8;
  localparam int unsigned ADDR_W = ROW_W + COL_W;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PH_W   = 8;

  localparam int unsigned DEF_T_RCD          = 4;
  localparam int unsigned DEF_T_CAS          = 6;
  localparam int unsigned DEF_T_RP           = 4;
  localparam int unsigned DEF_T_RAS_REF      = 6;
  localparam int unsigned DEF_REFRESH_PERIOD = 1024;

  typedef enum logic [3:0] {
    IDLE,
    ROW_SETUP,
    RAS_LOW,
    COL_SETUP,
    CAS_LOW,
    PRECHARGE,
    REF_SETUP,
    REF_RAS,
    REF_PRE
  } state_t;

  // Phase counter load value for a phase lasting 'cycles' clocks.
  function automatic logic [PH_W-1:0] phase_load(input int unsigned cycles);
    return PH_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dram_timing_gen_refresh_timer.sv
// Free-running refresh period timer with single pending flag, sticky overrun and row counter.
module refresh_timer
  import dram_timing_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refresh_taken,
  output logic             pending,
  output logic             overrun,
  output logic [ROW_W-1:0] row
);

  localparam int unsigned CNT_W = $clog2(PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(PERIOD - 1));

  // The row advances when the refresh is taken; the FSM latches the old row on that same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      row     <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (refresh_taken) row <= row + ROW_W'(1);
      if (wrap) begin
        pending <= 1'b1;
        if (pending && !refresh_taken) overrun <= 1'b1;
      end else if (refresh_taken) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dram_timing_gen.sv
// Turns req/ack bus accesses into RAS/CAS/W/address strobes with periodic RAS-only refresh.
module dram_timing_gen
  import dram_timing_pkg::*;
#(
  parameter int unsigned T_RCD          = DEF_T_RCD,
  parameter int unsigned T_CAS          = DEF_T_CAS,
  parameter int unsigned T_RP           = DEF_T_RP,
  parameter int unsigned T_RAS_REF      = DEF_T_RAS_REF,
  parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              refresh_overrun,
  output logic              dram_rasn,
  output logic              dram_casn,
  output logic              dram_wn,
  output logic [ROW_W-1:0]  dram_a,
  output logic [DATA_W-1:0] dram_d,
  input  logic [DATA_W-1:0] dram_q
);

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [COL_W-1:0]  col_l;
  logic              we_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] q_hold;
  logic              pending;
  logic [ROW_W-1:0]  ref_row;
  logic              refresh_taken_c;

  assign refresh_taken_c = (state == IDLE) && pending;

  refresh_timer #(
    .PERIOD(REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .refresh_taken(refresh_taken_c),
    .pending      (pending),
    .overrun      (refresh_overrun),
    .row          (ref_row)
  );

  // Outputs are assigned on the edge entering the state they belong to, so they are all registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      col_l     <= '0;
      we_l      <= 1'b0;
      wdata_l   <= '0;
      q_hold    <= '0;
      ack       <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      dram_rasn <= 1'b1;
      dram_casn <= 1'b1;
      dram_wn   <= 1'b1;
      dram_a    <= '0;
      dram_d    <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            state  <= REF_SETUP;
            busy   <= 1'b1;
            dram_a <= ref_row;
          end else if (req) begin
            state   <= ROW_SETUP;
            busy    <= 1'b1;
            dram_a  <= addr[ADDR_W-1:COL_W];
            col_l   <= addr[COL_W-1:0];
            we_l    <= we;
            wdata_l <= wdata;
          end
        end
        ROW_SETUP: begin
          state     <= RAS_LOW;
          dram_rasn <= 1'b0;
          phase     <= phase_load(T_RCD);
        end
        RAS_LOW: begin
          if (phase == '0) begin
            state  <= COL_SETUP;
            dram_a <= col_l;
            if (we_l) begin
              dram_wn <= 1'b0;
              dram_d  <= wdata_l;
            end
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        COL_SETUP: begin
          state     <= CAS_LOW;
          dram_casn <= 1'b0;
          phase     <= phase_load(T_CAS);
        end
        CAS_LOW: begin
          if (phase == '0) begin
            if (!we_l) q_hold <= dram_q;
            state     <= PRECHARGE;
            dram_rasn <= 1'b1;
            dram_wn   <= 1'b1;
            phase     <= phase_load(T_RP);
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        PRECHARGE: begin
          // RASn has already risen; CASn follows one cycle later.
          if (phase == phase_load(T_RP)) dram_casn <= 1'b1;
          if (phase == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            ack   <= 1'b1;
            if (!we_l) rdata <= q_hold;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        REF_SETUP: begin
          state     <= REF_RAS;
          dram_rasn <= 1'b0;
          phase     <= phase_load(T_RAS_REF);
        end
        REF_RAS: begin
          if (phase == '0) begin
            state     <= REF_PRE;
            dram_rasn <= 1'b1;
            phase     <= phase_load(T_RP);
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        REF_PRE: begin
          if (phase == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
